// File: rtl/lcd_pkg.sv
// Shared command bytes, FSM encodings and the init-command lookup for the
// character-LCD text sequencer.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET   = 8'h38;
    localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
    localparam logic [7:0] LCD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_ENTRY      = 8'h06;
    localparam logic [7:0] LCD_LINE0_ADDR = 8'h80;
    localparam logic [7:0] LCD_LINE1_ADDR = 8'hC0;

    // Index of the clear command in the init list; it needs the long settle.
    localparam int INIT_CLEAR_IDX = 2;
    localparam int INIT_LAST_IDX  = 3;

    typedef enum logic [2:0] {
        S_LOAD,
        S_WAIT,
        S_DLY,
        S_NEXT,
        S_IDLE
    } state_t;

    typedef enum logic {
        PH_INIT,
        PH_TEXT
    } phase_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_CLEAR;
            default: return LCD_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/lcd_xfer_step.sv
// One-byte transfer engine: loads a byte, handshakes with the LCD controller,
// waits the settle delay, then acknowledges so the sequencer can advance.
module lcd_xfer_step
    import lcd_pkg::*;
#(
    parameter int DLY_CYCLES     = 262142,
    parameter int CLR_DLY_CYCLES = 262142
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iGo,
    input  logic [7:0] iByte,
    input  logic       iRs,
    input  logic       iLongDly,
    input  logic       iLCD_Done,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_Start,
    output logic       oAck,
    output logic       oIdle
);

    localparam int CW = $clog2(CLR_DLY_CYCLES + 1);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   lim_m1;

    assign lim_m1 = iLongDly ? CW'(CLR_DLY_CYCLES - 1) : CW'(DLY_CYCLES - 1);

    // State register; reset restarts at a byte load so init begins at once.
    always_ff @(posedge clk) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nx;
    end

    // Next-state: NEXT and IDLE both hand control back to the sequencer via iGo.
    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD:  state_nx = S_WAIT;
            S_WAIT:  if (iLCD_Done) state_nx = S_DLY;
            S_DLY:   if (cnt == lim_m1) state_nx = S_NEXT;
            S_NEXT,
            S_IDLE:  state_nx = iGo ? S_LOAD : S_IDLE;
            default: state_nx = S_LOAD;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        oAck  = (state == S_NEXT);
        oIdle = (state == S_IDLE);
    end

    // Registered controller interface and settle counter; data/RS hold until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            oLCD_DATA  <= '0;
            oLCD_RS    <= 1'b0;
            oLCD_Start <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    oLCD_DATA  <= iByte;
                    oLCD_RS    <= iRs;
                    oLCD_Start <= 1'b1;
                end
                S_WAIT: begin
                    if (iLCD_Done) begin
                        oLCD_Start <= 1'b0;
                        cnt        <= '0;
                    end
                end
                S_DLY: begin
                    if (cnt != lim_m1) cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lcd_text_seq.sv
// Character-LCD host sequencer: one init pass after reset, then refreshes
// NUM_LINES x NUM_COLS characters from a snapshot of iText.
module lcd_text_seq
    import lcd_pkg::*;
#(
    parameter int NUM_LINES      = 2,
    parameter int NUM_COLS       = 16,
    parameter int DLY_CYCLES     = 262142,
    parameter int CLR_DLY_CYCLES = 262142,
    parameter int AUTO_REFRESH   = 1
) (
    input  logic                            iCLK,
    input  logic                            iRST,
    input  logic [8*NUM_LINES*NUM_COLS-1:0] iText,
    input  logic                            iUpdate,
    output logic                            oBusy,
    output logic                            oFrameDone,
    output logic [7:0]                      oLCD_DATA,
    output logic                            oLCD_RS,
    output logic                            oLCD_Start,
    input  logic                            iLCD_Done
);

    localparam int NCH = NUM_LINES * NUM_COLS;
    localparam int TW  = 8 * NCH;
    // Index also walks the four init commands, so it needs at least 2 bits.
    localparam int IW  = ($clog2(NUM_COLS + 1) < 2) ? 2 : $clog2(NUM_COLS + 1);

    phase_t          phase;
    logic [IW-1:0]   idx;      // text phase: 0 = line address, 1..NUM_COLS = characters
    logic            line;
    logic            pending;
    logic [TW-1:0]   snapshot;

    logic            ack, idle, go;
    logic [7:0]      byte_sel;
    logic            rs_sel, long_dly;
    logic            last_init, line_end, frame_end, refresh_req;
    logic [TW-1:0]   text_shift;
    int              pos;

    lcd_xfer_step #(
        .DLY_CYCLES     (DLY_CYCLES),
        .CLR_DLY_CYCLES (CLR_DLY_CYCLES)
    ) u_step (
        .clk        (iCLK),
        .rst        (iRST),
        .iGo        (go),
        .iByte      (byte_sel),
        .iRs        (rs_sel),
        .iLongDly   (long_dly),
        .iLCD_Done  (iLCD_Done),
        .oLCD_DATA  (oLCD_DATA),
        .oLCD_RS    (oLCD_RS),
        .oLCD_Start (oLCD_Start),
        .oAck       (ack),
        .oIdle      (idle)
    );

    // Select the byte for the current position: init command, line address or snapshot character.
    always_comb begin
        byte_sel   = '0;
        rs_sel     = 1'b0;
        long_dly   = 1'b0;
        pos        = 0;
        text_shift = '0;
        if (phase == PH_INIT) begin
            byte_sel = init_cmd(idx[1:0]);
            long_dly = (idx == IW'(INIT_CLEAR_IDX));
        end else if (idx == '0) begin
            byte_sel = line ? LCD_LINE1_ADDR : LCD_LINE0_ADDR;
        end else begin
            rs_sel     = 1'b1;
            pos        = int'(line) * NUM_COLS + int'(idx) - 1;
            text_shift = snapshot << (pos * 8);
            byte_sel   = text_shift[TW-1 -: 8];
        end
    end

    // Sequence-end decode and the go request for the transfer engine.
    always_comb begin
        last_init   = (phase == PH_INIT) && (idx == IW'(INIT_LAST_IDX));
        line_end    = (phase == PH_TEXT) && (idx == IW'(NUM_COLS));
        frame_end   = line_end && (line == 1'(NUM_LINES - 1));
        refresh_req = iUpdate || pending || ((AUTO_REFRESH != 0) && (iText != snapshot));
        go          = idle ? refresh_req : (ack && !frame_end);
        oFrameDone  = ack && frame_end;
        oBusy       = !idle;
    end

    // Index/line/phase advance, refresh-request latching and text snapshot.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            phase    <= PH_INIT;
            idx      <= '0;
            line     <= 1'b0;
            pending  <= 1'b0;
            snapshot <= '0;
        end else if (idle) begin
            if (refresh_req) begin
                snapshot <= iText;
                pending  <= 1'b0;
            end
        end else begin
            if (iUpdate) pending <= 1'b1;
            if (ack) begin
                if (phase == PH_INIT) begin
                    if (last_init) begin
                        phase    <= PH_TEXT;
                        idx      <= '0;
                        line     <= 1'b0;
                        snapshot <= iText;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end else if (line_end) begin
                    idx  <= '0;
                    line <= frame_end ? 1'b0 : line + 1'b1;
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_text_seq.sv
// Directed bench: three sequencer instances (2x16 manual, 2x16 auto, 1x8)
// each driven by a controller model that answers 3 cycles after a start.
module tb_lcd_text_seq;

    typedef struct packed {
        logic [7:0] d;
        logic       rs;
        int         t;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 2 lines x 16, manual refresh only
    logic         rst_a = 1'b1, upd_a = 1'b0, done_a = 1'b0;
    logic [255:0] text_a = '0;
    logic         busy_a, fd_a, rs_a, start_a;
    logic [7:0]   data_a;
    // 2 lines x 16, auto refresh
    logic         rst_b = 1'b1, upd_b = 1'b0, done_b = 1'b0;
    logic [255:0] text_b = '0;
    logic         busy_b, fd_b, rs_b, start_b;
    logic [7:0]   data_b;
    // 1 line x 8, manual refresh only
    logic         rst_c = 1'b1, upd_c = 1'b0, done_c = 1'b0;
    logic [63:0]  text_c = '0;
    logic         busy_c, fd_c, rs_c, start_c;
    logic [7:0]   data_c;

    lcd_text_seq #(.NUM_LINES(2), .NUM_COLS(16), .DLY_CYCLES(4), .CLR_DLY_CYCLES(10), .AUTO_REFRESH(0)) dut_a (
        .iCLK(clk), .iRST(rst_a), .iText(text_a), .iUpdate(upd_a), .oBusy(busy_a), .oFrameDone(fd_a),
        .oLCD_DATA(data_a), .oLCD_RS(rs_a), .oLCD_Start(start_a), .iLCD_Done(done_a));
    lcd_text_seq #(.NUM_LINES(2), .NUM_COLS(16), .DLY_CYCLES(4), .CLR_DLY_CYCLES(10), .AUTO_REFRESH(1)) dut_b (
        .iCLK(clk), .iRST(rst_b), .iText(text_b), .iUpdate(upd_b), .oBusy(busy_b), .oFrameDone(fd_b),
        .oLCD_DATA(data_b), .oLCD_RS(rs_b), .oLCD_Start(start_b), .iLCD_Done(done_b));
    lcd_text_seq #(.NUM_LINES(1), .NUM_COLS(8), .DLY_CYCLES(4), .CLR_DLY_CYCLES(10), .AUTO_REFRESH(0)) dut_c (
        .iCLK(clk), .iRST(rst_c), .iText(text_c), .iUpdate(upd_c), .oBusy(busy_c), .oFrameDone(fd_c),
        .oLCD_DATA(data_c), .oLCD_RS(rs_c), .oLCD_Start(start_c), .iLCD_Done(done_c));

    // Controller models plus byte/frame monitors (one per instance)
    ev_t q_a[$], q_b[$], q_c[$];
    int fdn_a = 0, fdn_b = 0, fdn_c = 0;
    logic sq_a = 1'b0, sq_b = 1'b0, sq_c = 1'b0;
    logic [1:0] cc_a = '0, cc_b = '0, cc_c = '0;

    always @(posedge clk) begin
        done_a <= 1'b0;
        if (rst_a) cc_a <= '0;
        else if (cc_a != 0) begin cc_a <= cc_a - 2'd1; if (cc_a == 2'd1) done_a <= 1'b1; end
        else if (start_a && !sq_a) cc_a <= 2'd2;
        if (start_a && !sq_a) q_a.push_back(ev_t'{d: data_a, rs: rs_a, t: cyc});
        sq_a <= start_a;
        if (fd_a) fdn_a <= fdn_a + 1;
    end
    always @(posedge clk) begin
        done_b <= 1'b0;
        if (rst_b) cc_b <= '0;
        else if (cc_b != 0) begin cc_b <= cc_b - 2'd1; if (cc_b == 2'd1) done_b <= 1'b1; end
        else if (start_b && !sq_b) cc_b <= 2'd2;
        if (start_b && !sq_b) q_b.push_back(ev_t'{d: data_b, rs: rs_b, t: cyc});
        sq_b <= start_b;
        if (fd_b) fdn_b <= fdn_b + 1;
    end
    always @(posedge clk) begin
        done_c <= 1'b0;
        if (rst_c) cc_c <= '0;
        else if (cc_c != 0) begin cc_c <= cc_c - 2'd1; if (cc_c == 2'd1) done_c <= 1'b1; end
        else if (start_c && !sq_c) cc_c <= 2'd2;
        if (start_c && !sq_c) q_c.push_back(ev_t'{d: data_c, rs: rs_c, t: cyc});
        sq_c <= start_c;
        if (fd_c) fdn_c <= fdn_c + 1;
    end

    // Expected {rs, byte} for position k (0..33) of a 2x16 refresh of text t
    function automatic logic [8:0] frame_byte(input logic [255:0] t, input int k);
        if (k == 0)  return {1'b0, 8'h80};
        if (k <= 16) return {1'b1, t[255 - 8*(k-1) -: 8]};
        if (k == 17) return {1'b0, 8'hC0};
        return {1'b1, t[255 - 8*(16 + k - 18) -: 8]};
    endfunction

    logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b want=1", busy_a); end
        checks++; if (fd_a !== 1'b0) begin failures++; $display("FAIL reset_framedone got=%b want=0", fd_a); end
        checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", data_a); end
        checks++; if (rs_a !== 1'b0) begin failures++; $display("FAIL reset_rs got=%b want=0", rs_a); end
        checks++; if (start_a !== 1'b0) begin failures++; $display("FAIL reset_start got=%b want=0", start_a); end
    endtask

    task automatic test_init_frame();
        int n = 0;
        int gap_norm, gap_clr;
        text_a = {"GUESS A NUMBER..", "TRIES: 0        "};
        rst_a = 1'b0;
        while (fdn_a < 1 && n < 3000) begin @(posedge clk); #1; n++; end
        checks++; if (fdn_a < 1) begin failures++; $display("FAIL init_timeout frames=%0d want=1", fdn_a); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (q_a.size() != 38) begin failures++; $display("FAIL init_count got=%0d want=38", q_a.size()); end
        checks++; if (fdn_a != 1) begin failures++; $display("FAIL init_framedone got=%0d want=1", fdn_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL init_idle busy=%b want=0", busy_a); end
        if (q_a.size() >= 38) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({q_a[i].rs, q_a[i].d} !== {1'b0, init_seq[i]}) begin
                    failures++; $display("FAIL init_cmd%0d got=%b/%h want=0/%h", i, q_a[i].rs, q_a[i].d, init_seq[i]);
                end
            end
            for (int k = 0; k < 34; k++) begin
                checks++;
                if ({q_a[4+k].rs, q_a[4+k].d} !== frame_byte(text_a, k)) begin
                    failures++; $display("FAIL init_frame_byte%0d got=%b/%h want=%h", k, q_a[4+k].rs, q_a[4+k].d, frame_byte(text_a, k));
                end
            end
            gap_norm = q_a[1].t - q_a[0].t;
            gap_clr  = q_a[3].t - q_a[2].t;
            checks++;
            if (gap_clr < 10 || gap_clr - gap_norm != 6) begin
                failures++; $display("FAIL clear_gap got=%0d normal=%0d want=normal+6", gap_clr, gap_norm);
            end
        end
    endtask

    task automatic test_no_auto();
        int base = q_a.size();
        int n = 0;
        text_a = {"GUESS A NUMBER..", "TRIES: 1        "};
        repeat (1000) @(posedge clk);
        #1;
        checks++; if (q_a.size() != base) begin failures++; $display("FAIL noauto_bytes got=%0d want=%0d", q_a.size(), base); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL noauto_busy got=%b want=0", busy_a); end
        upd_a = 1'b1;
        @(posedge clk); #1;
        upd_a = 1'b0;
        checks++; if (start_a !== 1'b0) begin failures++; $display("FAIL upd_lat1 start=%b want=0", start_a); end
        @(posedge clk); #1;
        checks++; if (start_a !== 1'b1) begin failures++; $display("FAIL upd_lat2 start=%b want=1", start_a); end
        checks++; if ({rs_a, data_a} !== 9'h080) begin failures++; $display("FAIL upd_first got=%b/%h want=0/80", rs_a, data_a); end
        while (fdn_a < 2 && n < 3000) begin @(posedge clk); #1; n++; end
        checks++; if (fdn_a != 2) begin failures++; $display("FAIL upd_frame frames=%0d want=2", fdn_a); end
        if (q_a.size() >= base + 34) begin
            for (int k = 0; k < 34; k++) begin
                checks++;
                if ({q_a[base+k].rs, q_a[base+k].d} !== frame_byte(text_a, k)) begin
                    failures++; $display("FAIL upd_frame_byte%0d got=%b/%h want=%h", k, q_a[base+k].rs, q_a[base+k].d, frame_byte(text_a, k));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int base = q_a.size();
        int fd0 = fdn_a;
        int n = 0;
        repeat (3) @(posedge clk);
        #1;
        upd_a = 1'b1; @(posedge clk); #1; upd_a = 1'b0;
        repeat (50) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1; upd_a = 1'b1; @(posedge clk); #1; upd_a = 1'b0;
            repeat (20) @(posedge clk);
        end
        #1;
        while (fdn_a < fd0 + 2 && n < 4000) begin @(posedge clk); #1; n++; end
        repeat (600) @(posedge clk);
        #1;
        checks++; if (fdn_a - fd0 != 2) begin failures++; $display("FAIL b2b_frames got=%0d want=2", fdn_a - fd0); end
        checks++; if (q_a.size() - base != 68) begin failures++; $display("FAIL b2b_bytes got=%0d want=68", q_a.size() - base); end
    endtask

    task automatic test_reset_mid();
        int base = q_a.size();
        int fd0 = fdn_a;
        int n = 0;
        upd_a = 1'b1; @(posedge clk); #1; upd_a = 1'b0;
        while (q_a.size() < base + 9 && n < 2000) begin @(posedge clk); #1; n++; end
        checks++; if (q_a.size() != base + 9) begin failures++; $display("FAIL rstmid_reach got=%0d want=%0d", q_a.size() - base, 9); end
        if (q_a.size() >= base + 9) begin
            checks++;
            if ({q_a[base+8].rs, q_a[base+8].d} !== frame_byte(text_a, 8)) begin
                failures++; $display("FAIL rstmid_byte7 got=%b/%h want=%h", q_a[base+8].rs, q_a[base+8].d, frame_byte(text_a, 8));
            end
        end
        rst_a = 1'b1;
        @(posedge clk); #1;
        checks++; if (start_a !== 1'b0) begin failures++; $display("FAIL rstmid_start got=%b want=0", start_a); end
        checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h want=00", data_a); end
        checks++; if (rs_a !== 1'b0) begin failures++; $display("FAIL rstmid_rs got=%b want=0", rs_a); end
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL rstmid_busy got=%b want=1", busy_a); end
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        n = 0;
        while (q_a.size() < base + 10 && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (q_a.size() < base + 10) begin
            failures++; $display("FAIL rstmid_restart no byte after release");
        end else if ({q_a[base+9].rs, q_a[base+9].d} !== 9'h038) begin
            failures++; $display("FAIL rstmid_restart got=%b/%h want=0/38", q_a[base+9].rs, q_a[base+9].d);
        end
        n = 0;
        while (fdn_a < fd0 + 1 && n < 3000) begin @(posedge clk); #1; n++; end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (fdn_a - fd0 != 1) begin failures++; $display("FAIL rstmid_frames got=%0d want=1", fdn_a - fd0); end
    endtask

    task automatic test_snapshot();
        logic [255:0] all_a, all_b;
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            all_a[i*8 +: 8] = 8'h41;
            all_b[i*8 +: 8] = 8'h42;
        end
        text_b = all_a;
        @(posedge clk); #1;
        rst_b = 1'b0;
        while (q_b.size() < 10 && n < 2000) begin @(posedge clk); #1; n++; end
        text_b = all_b;
        n = 0;
        while (fdn_b < 2 && n < 4000) begin @(posedge clk); #1; n++; end
        repeat (600) @(posedge clk);
        #1;
        checks++; if (fdn_b != 2) begin failures++; $display("FAIL snap_frames got=%0d want=2", fdn_b); end
        checks++; if (q_b.size() != 72) begin failures++; $display("FAIL snap_bytes got=%0d want=72", q_b.size()); end
        if (q_b.size() >= 72) begin
            for (int k = 0; k < 34; k++) begin
                checks++;
                if ({q_b[4+k].rs, q_b[4+k].d} !== frame_byte(all_a, k)) begin
                    failures++; $display("FAIL snap_old_byte%0d got=%b/%h want=%h", k, q_b[4+k].rs, q_b[4+k].d, frame_byte(all_a, k));
                end
                checks++;
                if ({q_b[38+k].rs, q_b[38+k].d} !== frame_byte(all_b, k)) begin
                    failures++; $display("FAIL snap_new_byte%0d got=%b/%h want=%h", k, q_b[38+k].rs, q_b[38+k].d, frame_byte(all_b, k));
                end
            end
        end
    endtask

    task automatic test_one_line();
        logic [63:0] t = "LCD TEST";
        int n = 0;
        int c0 = 0;
        text_c = t;
        @(posedge clk); #1;
        rst_c = 1'b0;
        while (fdn_c < 1 && n < 3000) begin @(posedge clk); #1; n++; end
        repeat (100) @(posedge clk);
        #1;
        checks++; if (fdn_c != 1) begin failures++; $display("FAIL one_frames got=%0d want=1", fdn_c); end
        checks++; if (q_c.size() != 13) begin failures++; $display("FAIL one_bytes got=%0d want=13", q_c.size()); end
        foreach (q_c[i]) if (q_c[i].rs == 1'b0 && q_c[i].d == 8'hC0) c0++;
        checks++; if (c0 != 0) begin failures++; $display("FAIL one_line1_addr got=%0d want=0", c0); end
        if (q_c.size() >= 13) begin
            for (int i = 0; i < 13; i++) begin
                logic [8:0] e;
                if (i < 4)       e = {1'b0, init_seq[i]};
                else if (i == 4) e = {1'b0, 8'h80};
                else             e = {1'b1, t[63 - 8*(i-5) -: 8]};
                checks++;
                if ({q_c[i].rs, q_c[i].d} !== e) begin
                    failures++; $display("FAIL one_byte%0d got=%b/%h want=%h", i, q_c[i].rs, q_c[i].d, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_frame();
        test_no_auto();
        test_back_to_back();
        test_reset_mid();
        test_snapshot();
        test_one_line();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
